bool_rr_arbiter: RTL and testbench



---
 rtl/bool_rr_arbiter.sv | 117 +++++++++++
 tb/tb_bool_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bool_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NR_OF_REQ requesters.
// Grants are held per burst and released on last beat or forced at MAX_BURST_P beats.
module bool_rr_arbiter #(
    parameter int NR_OF_REQ    = 4,
    parameter int DATA_WIDTH_P = 32,
    parameter int MAX_BURST_P  = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_enable,
    input  logic [NR_OF_REQ-1:0]              req_valid,
    input  logic [NR_OF_REQ-1:0]              req_last,
    input  logic [NR_OF_REQ*DATA_WIDTH_P-1:0] req_data,
    output logic [NR_OF_REQ-1:0]              req_ready,
    output logic                              out_valid,
    output logic                              out_last,
    output logic [DATA_WIDTH_P-1:0]           out_data,
    input  logic                              out_ready,
    output logic [NR_OF_REQ-1:0]              gnt,
    output logic [$clog2(NR_OF_REQ)-1:0]      gnt_id,
    output logic                              busy,
    output logic                              burst_cut
);

    localparam int          ID_W      = $clog2(NR_OF_REQ);
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BURST_P - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    int unsigned     scan_idx;
    logic [15:0]     beat_cnt;
    logic            start;
    logic            xfer;
    logic            release_now;
    logic            cut_now;

    // First requesting index at or above rr_ptr, wrapping past NR_OF_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NR_OF_REQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NR_OF_REQ;
            if (!win_found && req_valid[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    assign start       = (state == IDLE) && cfg_enable && win_found;
    assign xfer        = out_valid && out_ready;
    assign release_now = (state == BUSY) && xfer && (out_last || (beat_cnt == LAST_BEAT));
    assign cut_now     = release_now && !out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = BUSY;
            BUSY:    if (release_now) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Gating everything by the one-hot gnt keeps the channel quiet while idle.
    always_comb begin
        out_valid = |(req_valid & gnt);
        out_last  = |(req_last & gnt);
        out_data  = '0;
        for (int unsigned i = 0; i < NR_OF_REQ; i++) begin
            if (gnt[i]) begin
                out_data = out_data | req_data[i*DATA_WIDTH_P +: DATA_WIDTH_P];
            end
        end
        req_ready = gnt & {NR_OF_REQ{out_ready}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            burst_cut <= 1'b0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else begin
            burst_cut <= 1'b0;
            if (start) begin
                gnt      <= NR_OF_REQ'(1) << win_id;
                gnt_id   <= win_id;
                busy     <= 1'b1;
                beat_cnt <= '0;
            end else if (release_now) begin
                gnt       <= '0;
                busy      <= 1'b0;
                burst_cut <= cut_now;
                rr_ptr    <= (gnt_id == ID_W'(NR_OF_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end else if ((state == BUSY) && xfer) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bool_rr_arbiter.sv
// Directed bench for bool_rr_arbiter: requester models feed beats, and a scoreboard
// of expected grants and output beats is checked as the DUT produces them.
module tb_bool_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk;
    logic            rst;
    logic            cfg_enable;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [N-1:0]    gnt;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            burst_cut;

    bool_rr_arbiter #(
        .NR_OF_REQ   (N),
        .DATA_WIDTH_P(DW),
        .MAX_BURST_P (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_enable(cfg_enable),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .burst_cut (burst_cut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the sequence ended");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    // Requester model: rem = beats still to send, mode 0 = last on final beat,
    // 1 = never last, 2 = every beat last.
    int rem[N];
    int seq[N];
    int mode[N];
    int exp_seq[N];

    logic [32:0] exp_beats[$];
    int          exp_gnts[$];

    logic [N-1:0] prev_gnt = '0;
    logic         rst_q    = 1'b1;
    logic         rel_pend = 1'b0;
    logic         cut_pend = 1'b0;
    int           bcnt     = 0;
    int           cut_seen = 0;
    int           cycle_n  = 0;
    int           last_gs  = -1;
    int           exp_gap  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = rem[i] > 0;
            req_last[i]           = (rem[i] > 0) && (mode[i] == 2 || (mode[i] == 0 && rem[i] == 1));
            req_data[i*DW +: DW]  = {8'(i), 8'h5A, 16'(seq[i])};
        end
    endtask

    task automatic exp_beat(input int id, input logic last);
        exp_beats.push_back({last, 8'(id), 8'h5A, 16'(exp_seq[id])});
        exp_seq[id]++;
    endtask

    task automatic exp_grant(input int id);
        exp_gnts.push_back(id);
    endtask

    task automatic monitor();
        logic [32:0] eb;
        int          eg;
        chk("req_ready", 64'(req_ready), 64'(gnt & {N{out_ready}}));
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        chk("busy", 64'(busy), 64'(gnt != '0));
        if (gnt == '0) chk("idle_out", 64'({out_valid, out_last, out_data}), 64'd0);
        if (!rst_q && prev_gnt != '0) begin
            chk("release", 64'(gnt == '0), 64'(rel_pend));
            chk("burst_cut", 64'(burst_cut), 64'((gnt == '0) ? cut_pend : 1'b0));
            if (gnt != '0) chk("gnt_hold", 64'(gnt), 64'(prev_gnt));
        end else begin
            chk("cut_quiet", 64'(burst_cut), 64'd0);
        end
        if (burst_cut) cut_seen++;
        if (gnt != '0 && prev_gnt == '0) begin
            if (exp_gnts.size() == 0) begin
                chk("grant_unexpected", 64'(gnt), 64'd0);
            end else begin
                eg = exp_gnts.pop_front();
                chk("gnt", 64'(gnt), 64'(1) << eg);
                chk("gnt_id", 64'(gnt_id), 64'(eg));
                if (exp_gap != 0 && last_gs >= 0) chk("grant_gap", 64'(cycle_n - last_gs), 64'(exp_gap));
            end
            last_gs = cycle_n;
            bcnt    = 0;
        end
        rel_pend = 1'b0;
        cut_pend = 1'b0;
        if (out_valid && out_ready) begin
            bcnt++;
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 64'(out_valid), 64'd0);
            end else begin
                eb = exp_beats.pop_front();
                chk("out_data", 64'(out_data), 64'(eb[31:0]));
                chk("out_last", 64'(out_last), 64'(eb[32]));
            end
            rel_pend = out_last || (bcnt == MB);
            cut_pend = !out_last && (bcnt == MB);
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic cyc();
        drive();
        @(negedge clk);
        monitor();
        rst_q = rst;
        @(posedge clk);
        #1;
        cycle_n++;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            cyc();
            n++;
        end while ((exp_beats.size() != 0 || exp_gnts.size() != 0 || busy) && n < budget);
        chk("beats_left", 64'(exp_beats.size()), 64'd0);
        chk("grants_left", 64'(exp_gnts.size()), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; mode[i] = 0; exp_seq[i] = 0;
        end
        rst        = 1'b1;
        cfg_enable = 1'b0;
        out_ready  = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cut", 64'(burst_cut), 64'd0);
        chk("rst_out", 64'({req_ready, out_valid, out_last, out_data}), 64'd0);
        rst        = 1'b0;
        cfg_enable = 1'b1;
        out_ready  = 1'b1;

        // Single 3-beat burst from requester 0, then confirm rr_ptr moved to 1.
        rem[0] = 3;
        exp_grant(0);
        exp_beat(0, 1'b0); exp_beat(0, 1'b0); exp_beat(0, 1'b1);
        drive();
        #1;
        chk("pre_grant", 64'(gnt), 64'd0);
        cyc();
        chk("grant_latency", 64'(gnt), 64'b0001);
        run_until_idle(20);
        rem[0] = 1; rem[1] = 1;
        exp_grant(1); exp_beat(1, 1'b1);
        exp_grant(0); exp_beat(0, 1'b1);
        run_until_idle(20);

        // All four requesting single-beat bursts from rr_ptr 0.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_gap = 2;
        last_gs = -1;
        for (int i = 0; i < N; i++) mode[i] = 2;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        exp_grant(0); exp_beat(0, 1'b1);
        exp_grant(1); exp_beat(1, 1'b1);
        exp_grant(2); exp_beat(2, 1'b1);
        exp_grant(3); exp_beat(3, 1'b1);
        exp_grant(0); exp_beat(0, 1'b1);
        run_until_idle(30);
        exp_gap = 0;
        for (int i = 0; i < N; i++) mode[i] = 0;

        // Move rr_ptr to 2, then requests 0 and 1 must wrap to 0 first.
        rem[1] = 1;
        exp_grant(1); exp_beat(1, 1'b1);
        run_until_idle(20);
        rem[0] = 2; rem[1] = 2;
        exp_grant(0); exp_beat(0, 1'b0); exp_beat(0, 1'b1);
        exp_grant(1); exp_beat(1, 1'b0); exp_beat(1, 1'b1);
        run_until_idle(30);

        // 10-beat stream on requester 1 is cut every MB beats; requester 3 slips in.
        rem[1] = 10;
        exp_grant(1);
        for (int b = 0; b < 4; b++) exp_beat(1, 1'b0);
        exp_grant(3); exp_beat(3, 1'b1);
        exp_grant(1);
        for (int b = 0; b < 4; b++) exp_beat(1, 1'b0);
        exp_grant(1); exp_beat(1, 1'b0); exp_beat(1, 1'b1);
        cyc();
        rem[3] = 1;
        run_until_idle(60);
        chk("cut_count", 64'(cut_seen), 64'd2);

        // Disable mid-burst with a stalled beat; no new grant until re-enabled.
        rem[0] = 3;
        exp_grant(0);
        exp_beat(0, 1'b0); exp_beat(0, 1'b0); exp_beat(0, 1'b1);
        cyc();
        cyc();
        cfg_enable = 1'b0;
        out_ready  = 1'b0;
        rem[2]     = 1;
        drive();
        #1;
        chk("stall_valid", 64'(out_valid), 64'd1);
        cyc();
        out_ready = 1'b1;
        cyc();
        cyc();
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("disabled_idle", 64'(gnt), 64'd0);
        end
        exp_grant(2); exp_beat(2, 1'b1);
        cfg_enable = 1'b1;
        cyc();
        chk("enable_latency", 64'(gnt), 64'b0100);
        run_until_idle(20);

        // Reset during beat 2 of a 5-beat burst; pending 2 and 3 then go from rr_ptr 0.
        rem[1] = 5;
        exp_grant(1);
        exp_beat(1, 1'b0); exp_beat(1, 1'b0);
        cyc();
        rem[2] = 1; rem[3] = 1;
        cyc();
        rst = 1'b1;
        cyc();
        rem[1] = 0;
        drive();
        #1;
        chk("abort_gnt", 64'(gnt), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_gnt_id", 64'(gnt_id), 64'd0);
        rst = 1'b0;
        exp_grant(2); exp_beat(2, 1'b1);
        exp_grant(3); exp_beat(3, 1'b1);
        cyc();
        chk("rst_regrant", 64'(gnt), 64'b0100);
        run_until_idle(20);
        cyc();
        cyc();
        chk("cut_total", 64'(cut_seen), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
